aukv_dmem_resp: RTL and testbench

- Data-memory responder: the target end of the core's data-memory interface (en/we/addr/data/strobe in; data/valid out).
- Accepts one single-beat request at a time and performs byte-lane alignment from a low-justified strobe/data.
- Stores into an internal word array and returns a one-cycle valid pulse after a programmable number of wait states.
- Sits between the pipeline's memory stage and on-chip data RAM. It is also the bench model for memory-stage stall testing.

---
 rtl/aukv_pkg.sv | 19 +
 rtl/aukv_dmem_array.sv | 26 ++
 rtl/aukv_dmem_resp.sv | 104 ++++++++++
 tb/tb_aukv_dmem_resp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aukv_pkg.sv
// rtl/aukv_pkg.sv - shared strobe codes, FSM encoding and lane helper for the data-memory responder
package aukv_pkg;

    localparam logic [3:0] STRB_B = 4'h1;
    localparam logic [3:0] STRB_H = 4'h3;
    localparam logic [3:0] STRB_W = 4'hf;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Upper nibble non-zero means the access spills past the end of the word.
    function automatic logic [7:0] lane_strobe(input logic [3:0] strb, input logic [1:0] off);
        return {4'b0000, strb} << off;
    endfunction

endpackage

// File: rtl/aukv_dmem_array.sv
// rtl/aukv_dmem_array.sv - word RAM with per-byte write enables, synchronous read, no reset
module aukv_dmem_array #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge i_clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/aukv_dmem_resp.sv
// rtl/aukv_dmem_resp.sv - single-outstanding data-memory target with byte-lane alignment and wait states
module aukv_dmem_resp
    import aukv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_mem_en,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic [3:0]  i_mem_strobe,
    output logic [31:0] o_mem_data,
    output logic        o_mem_valid,
    output logic        o_mem_err
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
        $error("aukv_dmem_resp: LATENCY must be within 1..15");
    end

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic        req_we;
    logic        req_err;
    logic [1:0]  req_off;

    logic [1:0]  off;
    logic [7:0]  lane_strb;
    logic [31:0] lane_data;
    logic        in_range;
    logic        acc_err;
    logic        accept;
    logic [3:0]  ram_we;
    logic [31:0] rd_word;

    assign off       = i_mem_addr[1:0];
    assign lane_strb = lane_strobe(i_mem_strobe, off);
    assign lane_data = i_mem_data << {off, 3'b000};
    // Base is aligned to the array size, so range reduces to matching the upper address bits.
    assign in_range  = (i_mem_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign acc_err   = (|lane_strb[7:4]) | ~in_range;
    assign accept    = i_mem_en & ((state == IDLE) | (state == RESP));
    assign ram_we    = (accept & i_mem_we & ~acc_err) ? lane_strb[3:0] : 4'b0000;

    aukv_dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk (i_clk),
        .en    (accept),
        .we    (ram_we),
        .addr  (i_mem_addr[ADDR_W+1:2]),
        .wdata (lane_data),
        .rdata (rd_word)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_we      <= 1'b0;
            req_err     <= 1'b0;
            req_off     <= 2'd0;
            o_mem_valid <= 1'b0;
            o_mem_err   <= 1'b0;
            o_mem_data  <= 32'd0;
        end else begin
            o_mem_valid <= 1'b0;
            // Leaving RESP is the valid edge; rd_word still holds the word read at capture.
            if (state == RESP) begin
                o_mem_valid <= 1'b1;
                o_mem_err   <= req_err;
                if (!req_we) begin
                    o_mem_data <= req_err ? 32'd0 : (rd_word >> {req_off, 3'b000});
                end
            end
            if (accept) begin
                req_we  <= i_mem_we;
                req_err <= acc_err;
                req_off <= off;
                cnt     <= CNT_INIT;
                state   <= (LATENCY == 1) ? RESP : WAIT;
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt == 4'd0) begin
                            state <= RESP;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    RESP:    state <= IDLE;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aukv_dmem_resp.sv
// tb/tb_aukv_dmem_resp.sv - self-checking bench for aukv_dmem_resp against a transaction-level model
module tb_aukv_dmem_resp;
    import aukv_pkg::*;

    localparam int unsigned ADDR_W = 12;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          LAT    = 2;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_mem_en;
    logic        i_mem_we;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic [3:0]  i_mem_strobe;
    logic [31:0] o_mem_data;
    logic        o_mem_valid;
    logic        o_mem_err;

    always #5 i_clk = ~i_clk;

    aukv_dmem_resp #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_mem_en     (i_mem_en),
        .i_mem_we     (i_mem_we),
        .i_mem_addr   (i_mem_addr),
        .i_mem_data   (i_mem_data),
        .i_mem_strobe (i_mem_strobe),
        .o_mem_data   (o_mem_data),
        .o_mem_valid  (o_mem_valid),
        .o_mem_err    (o_mem_err)
    );

    typedef struct {
        int          vedge;
        logic        err;
        logic        rd;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] mm [int];
    int          edge_cnt   = 0;
    int          busy_until = 0;
    int          checks     = 0;
    int          errors     = 0;
    int          pulses     = 0;
    int          last_pulse = 0;
    int          prev_pulse = 0;
    int          last_acc   = 0;
    logic [31:0] m_data     = 32'd0;
    logic        m_err      = 1'b0;
    bit          checking   = 1'b0;

    always @(posedge i_clk) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Transaction-level model: an access occupies the target for LAT edges and completes on the last one.
    task automatic model_accept(input int at, input bit we, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb);
        int          off;
        int          nb;
        int          idx;
        longint      a;
        bit          err;
        logic [31:0] w;
        resp_t       r;
        off = int'(addr[1:0]);
        case (strb)
            STRB_B:  nb = 1;
            STRB_H:  nb = 2;
            STRB_W:  nb = 4;
            default: nb = 0;
        endcase
        a   = longint'(addr) - longint'(BASE);
        err = (off + nb > 4) || (a < 0) || (a >= 4 * (longint'(1) << ADDR_W));
        idx = int'(a / 4);
        r.data = 32'd0;
        if (!err && we && nb > 0) begin
            w = mm.exists(idx) ? mm[idx] : 32'd0;
            for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = data[8*k +: 8];
            mm[idx] = w;
        end
        if (!err && !we) r.data = mm.exists(idx) ? (mm[idx] >> (8 * off)) : 32'hxxxx_xxxx;
        r.vedge = at + LAT;
        r.err   = err;
        r.rd    = !we;
        exp_q.push_back(r);
        busy_until = at + LAT;
        last_acc   = at;
    endtask

    // Called just after a rising edge; the values apply to the next edge.
    task automatic drive(input bit en, input bit we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        int nxt;
        nxt          = edge_cnt + 1;
        i_mem_en     = en;
        i_mem_we     = we;
        i_mem_addr   = addr;
        i_mem_data   = data;
        i_mem_strobe = strb;
        if (en && nxt >= busy_until) model_accept(nxt, we, addr, data, strb);
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 40 && edge_cnt < busy_until; i++) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        if (edge_cnt < busy_until) begin
            checks++;
            errors++;
            $display("FAIL timeout: edge %0d, response due at edge %0d", edge_cnt, busy_until);
        end
    endtask

    task automatic req(input bit we, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(posedge i_clk);
        #1 drive(1'b1, we, addr, data, strb);
        @(posedge i_clk);
        #1 drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_resp();
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy_until = 0;
        m_data     = 32'd0;
        m_err      = 1'b0;
    endtask

    always @(negedge i_clk) begin : cmp
        logic  ev;
        resp_t r;
        if (checking) begin
            ev = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].vedge == edge_cnt) begin
                ev    = 1'b1;
                r     = exp_q.pop_front();
                m_err = r.err;
                if (r.rd) m_data = r.data;
            end
            if (o_mem_valid === 1'b1) begin
                prev_pulse = last_pulse;
                last_pulse = edge_cnt;
                pulses++;
            end
            chk("valid", {31'd0, o_mem_valid}, {31'd0, ev});
            chk("err", {31'd0, o_mem_err}, {31'd0, m_err});
            chk("data", o_mem_data, m_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        i_rstn = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        #2 i_rstn = 1'b0;
        #1 checking = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'd0, o_mem_valid}, 32'd0);
        chk("rst_err", {31'd0, o_mem_err}, 32'd0);
        chk("rst_data", o_mem_data, 32'd0);
        i_rstn = 1'b1;

        req(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, STRB_W);
        chk("word_wr_err", {31'd0, o_mem_err}, 32'd0);
        chk("word_wr_latency", 32'(last_pulse - last_acc), 32'd2);
        req(1'b0, 32'h0001_0010, 32'd0, STRB_W);
        chk("word_rd_data", o_mem_data, 32'hDEAD_BEEF);

        req(1'b1, 32'h0001_0010, 32'h1122_3344, STRB_W);
        req(1'b1, 32'h0001_0013, 32'h0000_00A5, STRB_B);
        req(1'b0, 32'h0001_0010, 32'd0, STRB_W);
        chk("byte_merge_word", o_mem_data, 32'hA522_3344);
        chk("model_merge_word", mm[4], 32'hA522_3344);
        req(1'b0, 32'h0001_0013, 32'd0, STRB_B);
        chk("byte_rd_off3", o_mem_data, 32'h0000_00A5);

        req(1'b1, 32'h0001_0000, 32'hCAFE_F00D, STRB_W);
        req(1'b1, 32'h0001_0003, 32'h0000_BBBB, STRB_H);
        chk("misaligned_err", {31'd0, o_mem_err}, 32'd1);
        req(1'b0, 32'h0001_0000, 32'd0, STRB_W);
        chk("misaligned_nowrite", o_mem_data, 32'hCAFE_F00D);

        req(1'b0, 32'h0000_0040, 32'd0, STRB_W);
        chk("oor_rd_err", {31'd0, o_mem_err}, 32'd1);
        chk("oor_rd_data", o_mem_data, 32'd0);
        req(1'b1, 32'h0001_4000, 32'h1234_5678, STRB_W);
        chk("oor_wr_err", {31'd0, o_mem_err}, 32'd1);
        req(1'b0, 32'h0001_0000, 32'd0, STRB_W);
        chk("oor_no_alias", o_mem_data, 32'hCAFE_F00D);

        p0 = pulses;
        @(posedge i_clk);
        #1 drive(1'b1, 1'b0, 32'h0001_0010, 32'd0, STRB_W);
        @(posedge i_clk);
        #1 drive(1'b1, 1'b0, 32'h0001_0000, 32'd0, STRB_W);
        @(posedge i_clk);
        #1 drive(1'b1, 1'b0, 32'h0001_0013, 32'd0, STRB_B);
        @(posedge i_clk);
        #1 drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_resp();
        repeat (3) @(negedge i_clk);
        chk("b2b_pulses", 32'(pulses - p0), 32'd2);
        chk("b2b_spacing", 32'(last_pulse - prev_pulse), 32'd2);
        chk("b2b_last_data", o_mem_data, 32'h0000_00A5);

        p0 = pulses;
        @(posedge i_clk);
        #1 drive(1'b1, 1'b0, 32'h0001_0010, 32'd0, STRB_W);
        @(posedge i_clk);
        #1 drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        i_rstn = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        chk("rst_mid_no_valid", 32'(pulses - p0), 32'd0);
        chk("rst_mid_data", o_mem_data, 32'd0);
        req(1'b0, 32'h0001_0010, 32'd0, STRB_W);
        chk("rst_mid_persist", o_mem_data, 32'hA522_3344);

        for (int i = 0; i < 16; i++) begin
            req(1'b1, BASE + 32'(4 * i), $urandom, STRB_W);
        end

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [3:0]  s;
            int          sel;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = BASE + $urandom_range(0, 63);
            else if (sel == 8) a = $urandom_range(0, 32'h0000_FFFF);
            else               a = 32'h0001_4000 + $urandom_range(0, 32'h000F_FFFF);
            case ($urandom_range(0, 3))
                0:       s = STRB_B;
                1:       s = STRB_H;
                2:       s = STRB_W;
                default: s = 4'h0;
            endcase
            @(posedge i_clk);
            #1 drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom, s);
        end
        @(posedge i_clk);
        #1 drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_resp();
        repeat (2) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
